// File: rtl/pixel_op_pkg.sv
// Shared types and constants for the pixel point-operation pipeline.
// Optional feature macro: PIXOP_THRESH_EN (code 7 binarises when defined).
package pixel_op_pkg;

    // Operation codes latched on the SOF beat.
    typedef enum logic [2:0] {
        OP_BRIGHT_INC = 3'd0,
        OP_BRIGHT_DEC = 3'd1,
        OP_GRAY       = 3'd2,
        OP_INVERT     = 3'd3,
        OP_RED        = 3'd4,
        OP_GREEN      = 3'd5,
        OP_BLUE       = 3'd6,
        OP_THRESH     = 3'd7
    } op_e;

    // Luma weights; they sum to 256 so the >>8 gray never exceeds MAXV.
    localparam int W_R = 77;
    localparam int W_G = 150;
    localparam int W_B = 29;

    // Channel count and index order used by the packed channel arrays.
    localparam int NUM_CH = 3;
    localparam int CH_R   = 0;
    localparam int CH_G   = 1;
    localparam int CH_B   = 2;

    // Default pixel width and the matching pixel record.
    localparam int PIX_W_DEF = 8;
    typedef struct packed {
        logic [PIX_W_DEF-1:0] r;
        logic [PIX_W_DEF-1:0] g;
        logic [PIX_W_DEF-1:0] b;
    } pixel_t;

endpackage

// File: rtl/pixel_op_pipe_if.sv
// Stream bus for pixel_op_pipe: input beat + cfg, output beat, frame length.
// master = pixel source / writer side, slave = the pipeline.
interface pixel_op_pipe_if #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 20
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic             in_eof;
    logic [2:0]       select_oper;
    logic [PIX_W-1:0] value;
    logic [PIX_W-1:0] threshold;
    logic [PIX_W-1:0] red_in;
    logic [PIX_W-1:0] green_in;
    logic [PIX_W-1:0] blue_in;

    logic             out_valid;
    logic             out_ready;
    logic             out_sof;
    logic             out_eof;
    logic [PIX_W-1:0] red_out;
    logic [PIX_W-1:0] green_out;
    logic [PIX_W-1:0] blue_out;

    logic [CNT_W-1:0] frame_len;
    logic             frame_len_valid;

    modport master (
        output in_valid, in_sof, in_eof, select_oper, value, threshold,
               red_in, green_in, blue_in, out_ready,
        input  in_ready, out_valid, out_sof, out_eof,
               red_out, green_out, blue_out, frame_len, frame_len_valid
    );

    modport slave (
        input  in_valid, in_sof, in_eof, select_oper, value, threshold,
               red_in, green_in, blue_in, out_ready,
        output in_ready, out_valid, out_sof, out_eof,
               red_out, green_out, blue_out, frame_len, frame_len_valid
    );
endinterface

// File: rtl/pixel_op_alu.sv
// Stage-2 clamp/select for one pixel from the registered stage-1 terms.
// Code 7 binarises against thr only when PIXOP_THRESH_EN is defined,
// otherwise it passes the pixel through and thr is ignored.
module pixel_op_alu
    import pixel_op_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  op_e                            op,
    input  logic [PIX_W-1:0]               thr,
    input  logic [NUM_CH-1:0][PIX_W-1:0]   raw,
    input  logic [NUM_CH-1:0][PIX_W:0]     sum,
    input  logic [NUM_CH-1:0][PIX_W:0]     dif,
    input  logic [PIX_W+9:0]               acc,
    output logic [NUM_CH-1:0][PIX_W-1:0]   pix
);
    localparam logic [PIX_W-1:0] MAXV = '1;

    logic [PIX_W-1:0] gray;
    logic             unused_bits;

    // Weighted sum >> 8; the top two accumulator bits are always zero.
    assign gray = acc[PIX_W+7:8];
`ifdef PIXOP_THRESH_EN
    assign unused_bits = ^{acc[PIX_W+9:PIX_W+8], acc[7:0]};
`else
    assign unused_bits = ^{acc[PIX_W+9:PIX_W+8], acc[7:0], thr};
`endif

    // Per-op result select; sum/dif MSB is the carry/borrow used to clamp.
    always_comb begin
        pix = '0;
        case (op)
            OP_BRIGHT_INC: begin
                for (int c = 0; c < NUM_CH; c++)
                    pix[c] = sum[c][PIX_W] ? MAXV : sum[c][PIX_W-1:0];
            end
            OP_BRIGHT_DEC: begin
                for (int c = 0; c < NUM_CH; c++)
                    pix[c] = dif[c][PIX_W] ? '0 : dif[c][PIX_W-1:0];
            end
            OP_GRAY:   pix = {NUM_CH{gray}};
            OP_INVERT: begin
                for (int c = 0; c < NUM_CH; c++)
                    pix[c] = MAXV - raw[c];
            end
            OP_RED:    pix[CH_R] = raw[CH_R];
            OP_GREEN:  pix[CH_G] = raw[CH_G];
            OP_BLUE:   pix[CH_B] = raw[CH_B];
`ifdef PIXOP_THRESH_EN
            OP_THRESH: pix = (gray > thr) ? '0 : {NUM_CH{MAXV}};
`else
            OP_THRESH: pix = raw;
`endif
        endcase
    end
endmodule

// File: rtl/pixel_op_pipe.sv
// Streaming RGB point-operation engine: 2-stage valid/ready pipeline,
// per-frame cfg latch on SOF, saturating frame-length counter.
// Optional feature macro: PIXOP_THRESH_EN (keeps threshold cfg + compare).
module pixel_op_pipe
    import pixel_op_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int CNT_W = 20
) (
    input  logic           clk,
    input  logic           reset,
    pixel_op_pipe_if.slave bus
);
    localparam int ACC_W = PIX_W + 10;

    typedef logic [NUM_CH-1:0][PIX_W-1:0] chan_t;
    typedef logic [NUM_CH-1:0][PIX_W:0]   wide_t;

    // Handshake
    logic [2:1]       vld_pipe_q, vld_pipe_d;
    logic             s2_load, in_fire, out_fire;

    // Frame cfg
    op_e              cfg_op_q, cfg_op_d;
    logic [PIX_W-1:0] cfg_val_q, cfg_val_d;
    logic [PIX_W-1:0] alu_thr;

    // Stage 1
    chan_t            pix_in;
    chan_t            s1_raw_q, s1_raw_d;
    wide_t            s1_sum_q, s1_sum_d;
    wide_t            s1_dif_q, s1_dif_d;
    logic [ACC_W-1:0] s1_acc_q, s1_acc_d;
    op_e              s1_op_q, s1_op_d;
    logic             s1_sof_q, s1_sof_d, s1_eof_q, s1_eof_d;

    // Stage 2
    chan_t            alu_pix;
    chan_t            s2_pix_q, s2_pix_d;
    logic             s2_sof_q, s2_sof_d, s2_eof_q, s2_eof_d;

    // Frame counter
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] flen_q, flen_d;
    logic             flen_vld_q, flen_vld_d;

`ifdef PIXOP_THRESH_EN
    logic [PIX_W-1:0] cfg_thr_q, cfg_thr_d;
    logic [PIX_W-1:0] s1_thr_q, s1_thr_d;
    assign alu_thr = s1_thr_q;
`else
    logic unused_thr;
    assign unused_thr = ^bus.threshold;
    assign alu_thr    = '0;
`endif

    // Stage 2 accepts when empty or draining; stage 1 when empty or moving on.
    assign s2_load      = !vld_pipe_q[2] || bus.out_ready;
    assign bus.in_ready = !vld_pipe_q[1] || s2_load;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = vld_pipe_q[2] && bus.out_ready;
    assign pix_in       = {bus.blue_in, bus.green_in, bus.red_in};

    // Pipeline occupancy.
    always_comb begin
        vld_pipe_d[1] = in_fire || (vld_pipe_q[1] && !s2_load);
        vld_pipe_d[2] = s2_load ? vld_pipe_q[1] : vld_pipe_q[2];
    end

    // Cfg latch; the _d value is what the SOF beat itself computes with.
    always_comb begin
        cfg_op_d  = cfg_op_q;
        cfg_val_d = cfg_val_q;
`ifdef PIXOP_THRESH_EN
        cfg_thr_d = cfg_thr_q;
`endif
        if (in_fire && bus.in_sof) begin
            cfg_op_d  = op_e'(bus.select_oper);
            cfg_val_d = bus.value;
`ifdef PIXOP_THRESH_EN
            cfg_thr_d = bus.threshold;
`endif
        end
    end

    // Stage 1: widened sums/differences and the weighted gray accumulator.
    always_comb begin
        s1_raw_d = s1_raw_q;
        s1_sum_d = s1_sum_q;
        s1_dif_d = s1_dif_q;
        s1_acc_d = s1_acc_q;
        s1_op_d  = s1_op_q;
        s1_sof_d = s1_sof_q;
        s1_eof_d = s1_eof_q;
`ifdef PIXOP_THRESH_EN
        s1_thr_d = s1_thr_q;
`endif
        if (in_fire) begin
            s1_raw_d = pix_in;
            for (int c = 0; c < NUM_CH; c++) begin
                s1_sum_d[c] = {1'b0, pix_in[c]} + {1'b0, cfg_val_d};
                s1_dif_d[c] = {1'b0, pix_in[c]} - {1'b0, cfg_val_d};
            end
            s1_acc_d = ACC_W'(W_R) * ACC_W'(bus.red_in)
                     + ACC_W'(W_G) * ACC_W'(bus.green_in)
                     + ACC_W'(W_B) * ACC_W'(bus.blue_in);
            s1_op_d  = cfg_op_d;
            s1_sof_d = bus.in_sof;
            s1_eof_d = bus.in_eof;
`ifdef PIXOP_THRESH_EN
            s1_thr_d = cfg_thr_d;
`endif
        end
    end

    pixel_op_alu #(.PIX_W(PIX_W)) u_alu (
        .op  (s1_op_q),
        .thr (alu_thr),
        .raw (s1_raw_q),
        .sum (s1_sum_q),
        .dif (s1_dif_q),
        .acc (s1_acc_q),
        .pix (alu_pix)
    );

    // Stage 2: capture the ALU result; held stable while stalled.
    always_comb begin
        s2_pix_d = s2_pix_q;
        s2_sof_d = s2_sof_q;
        s2_eof_d = s2_eof_q;
        if (s2_load && vld_pipe_q[1]) begin
            s2_pix_d = alu_pix;
            s2_sof_d = s1_sof_q;
            s2_eof_d = s1_eof_q;
        end
    end

    // Frame counter: restart on SOF, saturate, report length on EOF.
    always_comb begin
        cnt_d      = cnt_q;
        flen_d     = flen_q;
        flen_vld_d = 1'b0;
        if (out_fire) begin
            if (s2_sof_q)
                cnt_d = CNT_W'(1);
            else if (cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
            if (s2_eof_q) begin
                flen_d     = cnt_d;
                flen_vld_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe_q <= '0;
            cfg_op_q   <= OP_BRIGHT_INC;
            cfg_val_q  <= '0;
            s1_raw_q   <= '0;
            s1_sum_q   <= '0;
            s1_dif_q   <= '0;
            s1_acc_q   <= '0;
            s1_op_q    <= OP_BRIGHT_INC;
            s1_sof_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
            s2_pix_q   <= '0;
            s2_sof_q   <= 1'b0;
            s2_eof_q   <= 1'b0;
            cnt_q      <= '0;
            flen_q     <= '0;
            flen_vld_q <= 1'b0;
`ifdef PIXOP_THRESH_EN
            cfg_thr_q  <= '0;
            s1_thr_q   <= '0;
`endif
        end else begin
            vld_pipe_q <= vld_pipe_d;
            cfg_op_q   <= cfg_op_d;
            cfg_val_q  <= cfg_val_d;
            s1_raw_q   <= s1_raw_d;
            s1_sum_q   <= s1_sum_d;
            s1_dif_q   <= s1_dif_d;
            s1_acc_q   <= s1_acc_d;
            s1_op_q    <= s1_op_d;
            s1_sof_q   <= s1_sof_d;
            s1_eof_q   <= s1_eof_d;
            s2_pix_q   <= s2_pix_d;
            s2_sof_q   <= s2_sof_d;
            s2_eof_q   <= s2_eof_d;
            cnt_q      <= cnt_d;
            flen_q     <= flen_d;
            flen_vld_q <= flen_vld_d;
`ifdef PIXOP_THRESH_EN
            cfg_thr_q  <= cfg_thr_d;
            s1_thr_q   <= s1_thr_d;
`endif
        end
    end

    assign bus.out_valid       = vld_pipe_q[2];
    assign bus.out_sof         = s2_sof_q;
    assign bus.out_eof         = s2_eof_q;
    assign bus.red_out         = s2_pix_q[CH_R];
    assign bus.green_out       = s2_pix_q[CH_G];
    assign bus.blue_out        = s2_pix_q[CH_B];
    assign bus.frame_len       = flen_q;
    assign bus.frame_len_valid = flen_vld_q;
endmodule

// File: doc/pixel_op_pipe.md
# pixel_op_pipe

Streaming per-pixel RGB point-operation engine and the parametrised successor of the team's single-register pixel operator. It sits between the pixel source (frame reader / line buffer) and the output writer. It adds a valid/ready handshake with backpressure, a 2-stage pipeline, parametrised pixel width, per-frame latching of mode and operands, correct saturating arithmetic in both directions, and frame-length reporting.

## Interface
- PIX_W, 8: bits per colour channel; max code MAXV = 2^PIX_W-1.
- CNT_W, 20: width of the frame pixel counter.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- select_oper  in  3  operation code; sampled only on an accepted SOF beat.
- value  in  PIX_W  brightness offset; sampled with select_oper.
- threshold  in  PIX_W  binarisation level; sampled with select_oper.
- in_valid / in_ready  in / out  1  input handshake.
- in_sof / in_eof  in  1  first / last pixel of frame; both may be set on one beat.
- red_in, green_in, blue_in  in  PIX_W  input pixel.
- out_valid / out_ready  out / in  1  output handshake.
- out_sof / out_eof  out  1  frame markers, aligned with the pixel.
- red_out, green_out, blue_out  out  PIX_W  result pixel.
- frame_len  out  CNT_W  pixel count of the last completed frame.
- frame_len_valid  out  1  one-cycle pulse when frame_len updates.

## Operation
- A beat transfers when valid && ready on the same edge. in_ready = !v1 || !v2 || out_ready.
- Config latch:
  - On an accepted beat with in_sof=1, {select_oper, value, threshold} load into the cfg registers.
  - That beat and all later beats use the new cfg.
  - Beats accepted without a preceding SOF since reset use the reset cfg: mode 0, value 0, threshold 0, giving pass-through behaviour.
- Operation codes:
  - 0 BRIGHT_INC: each channel = min(c+value, MAXV), using a PIX_W+1-bit sum.
  - 1 BRIGHT_DEC: each channel = (c<value) ? 0 : c-value. No wrap.
  - 2 GRAY: g = (77R+150G+29B)>>8, using a PIX_W+10-bit accumulator; all channels = g. g never exceeds MAXV.
  - 3 INVERT: each channel = MAXV-c.
  - 4 RED / 5 GREEN / 6 BLUE: the named channel passes through; the other two are 0.
  - 7 THRESH: g as in GRAY; all channels = (g>threshold) ? 0 : MAXV. See Configuration.
- Stage 1 registers the products, sums, differences and cfg. Stage 2 performs clamp/select and drives the outputs. sof/eof travel alongside the data.
- Frame counter:
  - Increments on each output transfer.
  - On an output transfer with out_sof, the count restarts at 1.
  - On an output transfer with out_eof, frame_len ← count (including that beat) and frame_len_valid pulses the next cycle.
  - The counter saturates at 2^CNT_W-1.
- EOF missing before the next SOF: the counter simply restarts and frame_len is not updated.

## Timing
- Latency: 2 cycles from input transfer to out_valid, with out_ready held high. Throughput is 1 pixel/clock.
- Stall:
  - With out_ready=0, stage 2 holds its data and flags stable and out_valid stays high.
  - Stage 1 fills, then in_ready drops in the same cycle both stages are full.
  - There is no combinational path from in_valid to out_valid.
- out_valid never drops without a transfer.
- Reset values: out_valid 0, all pixel outputs 0, out_sof/out_eof 0, frame_len 0, frame_len_valid 0, counter 0, cfg 0. in_ready is 1 one cycle after deassertion.
- Reset mid-frame discards in-flight beats immediately; no partial frame_len is reported.
- select_oper changes between SOFs have no effect.

## Configuration
- PIXOP_THRESH_EN defined: code 7 is THRESH as above.
- PIXOP_THRESH_EN undefined: code 7 is pass-through (out = in). The threshold port stays present but unused, and its cfg register and comparator are removed.

## Structure
- Package pixel_op_pkg holds:
  - the op_e enum (codes 0–7);
  - gray weight constants W_R=77, W_G=150, W_B=29;
  - the pixel struct typedef {r,g,b} parametrised by PIX_W.
- Sub-module pixel_op_alu: the combinational stage-2 clamp/select for one pixel given the stage-1 terms and cfg. It is instantiated once. The top owns the handshake, cfg latch and counter.

## Test plan
- PIX_W=8, SOF with mode 0 and value 50; pixels (100,220,255) → (150,255,255) after 2 cycles; out_sof=1.
- Mode 1, value 60, pixel (30,60,200) → (0,0,140); no wrap to 226.
- Mode 2 on (255,255,255) → (255,255,255). Mode 2 on (100,50,200) → g=(7700+7500+5800)>>8=82 on all channels.
- Mode 7 with threshold 128: (255,255,255) → (0,0,0) and (10,10,10) → (255,255,255). Without the macro, (10,10,10) → (10,10,10).
- 5-pixel frame with out_ready toggled 1,0,0,1,…:
  - no pixel is lost or duplicated;
  - outputs are stable while stalled;
  - frame_len=5 with one pulse after the eof transfer.
- Assert reset while 2 beats are in flight: out_valid is 0 immediately and no frame_len_valid pulse occurs. The next SOF frame of 1 pixel (sof=eof=1) gives frame_len=1.
